// File: rtl/fdam_wr_req_gen_pkg.sv
// Shared types and default widths for the write-request generator.
package fdam_wr_req_gen_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_CREDIT_BITS = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fdam_wr_req_gen_if.sv
// Control/request bundle between the channel controller, the arbiter lane and the generator.
interface fdam_wr_req_gen_if #(
  parameter int DATA_WIDTH = fdam_wr_req_gen_pkg::DEF_DATA_WIDTH
);
  logic                  start;
  logic [DATA_WIDTH-1:0] base_addr;
  logic [DATA_WIDTH-1:0] num_lines;
  logic                  line_ready;
  logic                  req_wr_available;
  logic                  req_wr_en;
  logic [DATA_WIDTH-1:0] req_wr_data;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  modport master (
    input  start, base_addr, num_lines, line_ready, req_wr_available,
    output req_wr_en, req_wr_data, busy, done, overflow
  );

  modport slave (
    output start, base_addr, num_lines, line_ready, req_wr_available,
    input  req_wr_en, req_wr_data, busy, done, overflow
  );
endinterface

// File: rtl/fdam_credit_counter.sv
// Saturating up/down credit counter with a sticky overflow flag; shared by the read and write generators.
module fdam_credit_counter #(
  parameter int CREDIT_BITS = fdam_wr_req_gen_pkg::DEF_CREDIT_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc,
  input  logic                   dec,
  input  logic                   clr_ovf,
  output logic [CREDIT_BITS-1:0] count,
  output logic                   overflow
);

  localparam logic [CREDIT_BITS-1:0] MAX_CNT = '1;
  localparam logic [CREDIT_BITS-1:0] ONE     = CREDIT_BITS'(1);

  logic sat_hit;

  assign sat_hit = inc && !dec && (count == MAX_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (inc && !dec && !sat_hit)
        count <= count + ONE;
      else if (dec && !inc && (count != '0))
        count <= count - ONE;
      // a saturation event in the same cycle as a clear still leaves the flag set
      overflow <= sat_hit || (overflow && !clr_ovf);
    end
  end

endmodule

// File: rtl/fdam_wr_req_gen.sv
// Per-channel write-request generator: one line-address request per staged credit, up to num_lines.
//
// state   | meaning
// IDLE    | waiting for start after reset
// RUN     | issuing requests while credits and the arbiter lane allow
// DONE    | all requests issued (or num_lines was 0); waits for next start
module fdam_wr_req_gen
  import fdam_wr_req_gen_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int CREDIT_BITS = DEF_CREDIT_BITS
) (
  input  logic               clk,
  input  logic               rst,
  fdam_wr_req_gen_if.master  bus
);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   base_q, num_q, idx_q;
  logic [CREDIT_BITS-1:0]  credits;
  logic                    start_acc, issue, last;

  fdam_credit_counter #(.CREDIT_BITS(CREDIT_BITS)) u_credits (
    .clk      (clk),
    .rst      (rst),
    .inc      (bus.line_ready),
    .dec      (issue),
    .clr_ovf  (start_acc),
    .count    (credits),
    .overflow (bus.overflow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_acc = bus.start && (state_q != ST_RUN);
    issue     = (state_q == ST_RUN) && (credits != '0) && bus.req_wr_available
                && (idx_q < num_q);
    last      = (idx_q == num_q - ONE);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_acc)
          state_d = (bus.num_lines != '0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        if (issue && last)
          state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q          <= '0;
      num_q           <= '0;
      idx_q           <= '0;
      bus.req_wr_en   <= 1'b0;
      bus.req_wr_data <= '0;
    end else begin
      if (start_acc) begin
        base_q <= bus.base_addr;
        num_q  <= bus.num_lines;
        idx_q  <= '0;
      end else if (issue) begin
        idx_q <= idx_q + ONE;
      end
      bus.req_wr_en <= issue;
      // address wraps modulo 2^DATA_WIDTH
      if (issue)
        bus.req_wr_data <= base_q + idx_q;
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);

endmodule

// File: tb/tb_fdam_wr_req_gen.sv
// Directed and randomized checks of fdam_wr_req_gen against a transaction-level reference model.
module tb_fdam_wr_req_gen;

  localparam int DW   = 32;
  localparam int CB   = 5;
  localparam int MAXC = 31;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fdam_wr_req_gen_if #(.DATA_WIDTH(DW)) bus ();

  fdam_wr_req_gen #(.DATA_WIDTH(DW), .CREDIT_BITS(CB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // reference model: 0 = idle, 1 = running, 2 = finished
  int          m_phase;
  logic [31:0] m_base, m_num, m_idx;
  int          m_cr;
  bit          m_ovf;
  bit          e_en;
  logic [31:0] e_data;
  logic [31:0] got_q[$];
  int          n_before;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_base = '0; m_num = '0; m_idx = '0;
    m_cr = 0; m_ovf = 0; e_en = 0; e_data = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      bit iss;
      int old;
      old = m_phase;
      iss = (old == 1) && (m_cr > 0) && (bus.req_wr_available === 1'b1) && (m_idx < m_num);
      e_en = iss;
      if (iss) e_data = m_base + m_idx;
      if (bus.start && old != 1) begin
        m_base = bus.base_addr; m_num = bus.num_lines; m_idx = '0; m_ovf = 0;
        m_phase = (bus.num_lines != 0) ? 1 : 2;
      end else if (iss) begin
        m_idx = m_idx + 1;
        if (m_idx == m_num) m_phase = 2;
      end
      if (bus.line_ready && !iss) begin
        if (m_cr == MAXC) m_ovf = 1;
        else m_cr++;
      end else if (iss && !bus.line_ready) begin
        m_cr--;
      end
    end
    #1;
    chk("req_wr_en", 32'(bus.req_wr_en), 32'(e_en));
    if (e_en) chk("req_wr_data", bus.req_wr_data, e_data);
    chk("busy", 32'(bus.busy), 32'(m_phase == 1));
    chk("done", 32'(bus.done), 32'(m_phase == 2));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (bus.req_wr_en === 1'b1) got_q.push_back(bus.req_wr_data);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_start(input logic [31:0] base, input logic [31:0] num);
    bus.start = 1'b1; bus.base_addr = base; bus.num_lines = num;
    cycle();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.base_addr = '0; bus.num_lines = '0;
    bus.line_ready = 1'b0; bus.req_wr_available = 1'b0;
    rst = 1'b1;
    model_reset();
    run(2);
    rst = 1'b0;

    // basic run: credits staged before start
    bus.req_wr_available = 1'b1;
    bus.line_ready = 1'b1; run(4); bus.line_ready = 1'b0;
    got_q.delete();
    do_start(32'h1000, 32'd4);
    run(6);
    chk("basic_count", got_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("basic_data", got_q[i], 32'h1000 + i);
    chk("basic_done", 32'(bus.done), 32'd1);

    // credit throttle
    got_q.delete();
    do_start(32'h2000, 32'd3);
    for (int i = 0; i < 3; i++) begin
      run(4); bus.line_ready = 1'b1; cycle(); bus.line_ready = 1'b0;
    end
    run(4);
    chk("thr_count", got_q.size(), 32'd3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) chk("thr_data", got_q[i], 32'h2000 + i);

    // back-pressure with three credits left
    got_q.delete();
    bus.line_ready = 1'b1; run(5); bus.line_ready = 1'b0;
    do_start(32'h3000, 32'd5);
    run(2);
    bus.req_wr_available = 1'b0;
    n_before = got_q.size();
    run(10);
    chk("bp_window", got_q.size() - n_before, 32'd0);
    bus.req_wr_available = 1'b1;
    run(5);
    chk("bp_total", got_q.size(), 32'd5);

    // zero lines
    got_q.delete();
    do_start(32'h4000, 32'd0);
    chk("zero_done", 32'(bus.done), 32'd1);
    run(3);
    chk("zero_count", got_q.size(), 32'd0);

    // address wrap
    got_q.delete();
    bus.line_ready = 1'b1; run(3); bus.line_ready = 1'b0;
    do_start(32'hFFFF_FFFE, 32'd3);
    run(5);
    chk("wrap_count", got_q.size(), 32'd3);
    if (got_q.size() == 3) begin
      chk("wrap_d0", got_q[0], 32'hFFFF_FFFE);
      chk("wrap_d1", got_q[1], 32'hFFFF_FFFF);
      chk("wrap_d2", got_q[2], 32'h0000_0000);
    end

    // saturation, overflow, and line_ready coinciding with issue
    got_q.delete();
    bus.line_ready = 1'b1; run(32); bus.line_ready = 1'b0;
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    do_start(32'h5000, 32'd40);
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);
    bus.line_ready = 1'b1; run(5); bus.line_ready = 1'b0;
    run(40);
    chk("sat_count", got_q.size(), 32'd36);
    chk("sat_busy", 32'(bus.busy), 32'd1);
    bus.line_ready = 1'b1; run(4); bus.line_ready = 1'b0;
    run(3);
    chk("sat_total", got_q.size(), 32'd40);

    // asynchronous reset mid-run
    got_q.delete();
    bus.line_ready = 1'b1; run(8); bus.line_ready = 1'b0;
    do_start(32'h6000, 32'd8);
    run(2);
    chk("rst_pre_count", got_q.size(), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("rst_en", 32'(bus.req_wr_en), 32'd0);
    chk("rst_data", bus.req_wr_data, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    model_reset();
    cycle();
    rst = 1'b0;
    bus.line_ready = 1'b1; run(3); bus.line_ready = 1'b0;
    run(8);
    chk("rst_post_count", got_q.size(), 32'd2);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.line_ready       = ($urandom_range(0, 9) < 4);
      bus.req_wr_available = ($urandom_range(0, 9) < 7);
      bus.start            = ($urandom_range(0, 19) == 0);
      bus.base_addr        = $urandom;
      bus.num_lines        = $urandom_range(0, 6);
      cycle();
    end
    bus.start = 1'b0;
    bus.line_ready = 1'b1; bus.req_wr_available = 1'b1;
    run(20);
    bus.line_ready = 1'b0;
    run(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
